// File: rtl/bias_lane_pipe.sv
// bias_lane_pipe
//   Multi-lane bias stage between the accumulator tree and the activation/pool
//   stage. Per lane: out[i] = sat((a[i] + bias[ch][i] + rnd) >> SHIFT).
//   An on-chip bank holds one bias row per channel. The two pipeline stages
//   use valid/ready flow control.
//
// Parameters
//   SIZE    parallel lanes
//   DATA_W  unsigned width of each activation and output lane
//   BIAS_W  unsigned width of each bias entry
//   NUM_CH  bias bank depth (channels)
//   SHIFT   right shift applied after the add
//   ROUND   0 = truncate, 1 = round-half-up (only when SHIFT > 0)
//
// Ports
//   clock, reset                    rising-edge clock, async active-low reset
//   bias_wr_en/_addr/_data          write one bias row (lane i at [i*BIAS_W +: BIAS_W])
//   in_valid, in_ready, in_ch, a    input beat, bias row select, activation lanes
//   out_valid, out_ready, out       output beat, biased/shifted/saturated lanes
//   sat_count                       (BIAS_LANE_SAT_CNT_EN only) sticky count of clamped lanes
//
// Build option
//   BIAS_LANE_SAT_CNT_EN  adds the sat_count port and its counter.

module bias_lane_pipe #(
  parameter int SIZE   = 4,
  parameter int DATA_W = 8,
  parameter int BIAS_W = 8,
  parameter int NUM_CH = 4,
  parameter int SHIFT  = 1,
  parameter int ROUND  = 0,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   bias_wr_en,
  input  logic [CH_W-1:0]        bias_wr_addr,
  input  logic [SIZE*BIAS_W-1:0] bias_wr_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CH_W-1:0]        in_ch,
  input  logic [SIZE*DATA_W-1:0] a,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SIZE*DATA_W-1:0] out
`ifdef BIAS_LANE_SAT_CNT_EN
  ,
  output logic [15:0]            sat_count
`endif
);

  // Two guard bits above the wider operand hold a + bias + rounding constant.
  localparam int MW = (DATA_W > BIAS_W) ? DATA_W : BIAS_W;
  localparam int AW = MW + 2;
  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [AW-1:0] RND  = (ROUND != 0 && SHIFT > 0) ? AW'(64'd1 << RS) : '0;
  localparam logic [AW-1:0] MAXV = AW'((64'd1 << DATA_W) - 64'd1);

  logic [SIZE*BIAS_W-1:0] bank [NUM_CH];
  logic [SIZE*BIAS_W-1:0] row;

  logic                   s1_valid;
  logic [SIZE*DATA_W-1:0] s1_a;
  logic [SIZE*BIAS_W-1:0] s1_bias;
  logic                   s2_valid;
  logic [SIZE*DATA_W-1:0] s2_out;
  logic                   s2_load;

  logic [SIZE*DATA_W-1:0] lane_res;
  logic [SIZE-1:0]        lane_sat;

  // For a non-power-of-2 depth, channel codes past the bank read as a zero row.
  always_comb begin
    row = '0;
    if ({1'b0, in_ch} < (CH_W+1)'(NUM_CH))
      row = bank[in_ch];
  end

  // The bank is read combinationally before the edge, so a beat accepted in
  // the same cycle as a write to its channel picks up the old row.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++)
        bank[i] <= '0;
    end else if (bias_wr_en && ({1'b0, bias_wr_addr} < (CH_W+1)'(NUM_CH))) begin
      bank[bias_wr_addr] <= bias_wr_data;
    end
  end

  assign s2_load  = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_bias  <= '0;
      s2_valid <= 1'b0;
      s2_out   <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a    <= a;
          s1_bias <= row;
        end
      end
      // A bubble moving into S2 keeps the previous data; only out_valid drops.
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid)
          s2_out <= lane_res;
      end
    end
  end

  for (genvar g = 0; g < SIZE; g++) begin : g_lane
    logic [AW-1:0] sum;
    logic [AW-1:0] shr;
    assign sum = AW'(s1_a[g*DATA_W +: DATA_W]) + AW'(s1_bias[g*BIAS_W +: BIAS_W]) + RND;
    assign shr = sum >> SHIFT;
    assign lane_sat[g] = shr > MAXV;
    assign lane_res[g*DATA_W +: DATA_W] = lane_sat[g] ? {DATA_W{1'b1}} : shr[DATA_W-1:0];
  end

  assign out_valid = s2_valid;
  assign out       = s2_out;

`ifdef BIAS_LANE_SAT_CNT_EN
  logic [16:0] sat_add;
  logic [16:0] sat_sum;

  always_comb begin
    sat_add = '0;
    for (int i = 0; i < SIZE; i++)
      sat_add = sat_add + 17'(lane_sat[i]);
  end

  assign sat_sum = {1'b0, sat_count} + sat_add;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      sat_count <= '0;
    else if (s2_load && s1_valid)
      sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end
`endif

endmodule
